// File: rtl/counter_b4_event_log.sv
`default_nettype none
// ============================================================================
//  Module   : counter_b4_event_log
//  Purpose  : Timestamped event logger for a 4-bit counter. It detects rising
//             edges on the upstream rco and load indications and queues
//             {type, q, timestamp} entries in a small FIFO. A sticky flag
//             records any event that was dropped because the FIFO was full.
//  Revision : 1.0 - initial release
// ============================================================================
module counter_b4_event_log #(
    parameter int DEPTH = 4,
    parameter int TS_W  = 8
) (
    input  logic                      b4_clk,
    input  logic                      b4_reset,
    input  logic [3:0]                b4_Q,
    input  logic                      b4_load,
    input  logic                      b4_rco,
    input  logic                      b4_ovf_clr,
    input  logic                      ev_ready,
    output logic                      ev_valid,
    output logic [6+TS_W-1:0]         ev_data,
    output logic [$clog2(DEPTH):0]    ev_count,
    output logic                      ev_ovf
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_data_w = 6 + TS_W;
    localparam logic [c_addr_w:0] c_full_count = (c_addr_w + 1)'(DEPTH);

    logic [TS_W-1:0]     r_ts;
    logic                r_rco_q;
    logic                r_load_q;
    logic [c_data_w-1:0] r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_count;
    logic                r_ovf;

    logic                w_rco_edge;
    logic                w_load_edge;
    logic                w_event;
    logic [c_data_w-1:0] w_entry;
    logic                w_valid;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;

    // Edge detection against the previous-cycle level; both edges in one
    // cycle merge into a single entry of type 2'b11.
    assign w_rco_edge  = b4_rco  & ~r_rco_q;
    assign w_load_edge = b4_load & ~r_load_q;
    assign w_event     = w_rco_edge | w_load_edge;
    assign w_entry     = {w_load_edge, w_rco_edge, b4_Q, r_ts};

    // A pop only happens on a valid head, so ev_ready is inert when empty.
    // When full, an event is still accepted if the head leaves this cycle.
    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == c_full_count);
    assign w_pop   = w_valid & ev_ready;
    assign w_push  = w_event & (~w_full | w_pop);
    assign w_drop  = w_event & w_full & ~w_pop;

    assign ev_valid = w_valid;
    assign ev_data  = w_valid ? r_mem[r_rd_ptr] : '0;
    assign ev_count = r_count;
    assign ev_ovf   = r_ovf;

    // Free-running timestamp, wraps naturally at all-ones.
    always_ff @(posedge b4_clk) begin
        if (b4_reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    // Previous-cycle levels; reset to 1 so levels already high at reset
    // release are not mistaken for edges.
    always_ff @(posedge b4_clk) begin
        if (b4_reset) begin
            r_rco_q  <= 1'b1;
            r_load_q <= 1'b1;
        end else begin
            r_rco_q  <= b4_rco;
            r_load_q <= b4_load;
        end
    end

    // Entry storage; contents need no reset because occupancy is cleared.
    always_ff @(posedge b4_clk) begin
        if (w_push && !b4_reset) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // FIFO pointers and occupancy; reset discards everything queued.
    always_ff @(posedge b4_clk) begin
        if (b4_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge b4_clk) begin
        if (b4_reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (b4_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_counter_b4_event_log.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_b4_event_log
//  Purpose  : Directed self-checking bench for counter_b4_event_log.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_counter_b4_event_log;

    logic        clk;
    logic        b4_reset;
    logic [3:0]  b4_Q;
    logic        b4_load;
    logic        b4_rco;
    logic        b4_ovf_clr;
    logic        ev_ready;
    logic        ev_valid;
    logic [13:0] ev_data;
    logic [2:0]  ev_count;
    logic        ev_ovf;

    int tests_run;
    int tests_failed;
    int cyc;

    counter_b4_event_log #(
        .DEPTH (4),
        .TS_W  (8)
    ) dut (
        .b4_clk     (clk),
        .b4_reset   (b4_reset),
        .b4_Q       (b4_Q),
        .b4_load    (b4_load),
        .b4_rco     (b4_rco),
        .b4_ovf_clr (b4_ovf_clr),
        .ev_ready   (ev_ready),
        .ev_valid   (ev_valid),
        .ev_data    (ev_data),
        .ev_count   (ev_count),
        .ev_ovf     (ev_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        b4_reset = 1'b1;
        @(posedge clk);
        #1;
        b4_reset = 1'b0;
        cyc = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] ent(input logic [1:0] t, input logic [3:0] q, input logic [7:0] ts);
        return {t, q, ts};
    endfunction

    logic [13:0] exp_e [8];
    logic [13:0] exp_new;
    int          seen;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        b4_reset     = 1'b1;
        b4_Q         = 4'h0;
        b4_load      = 1'b0;
        b4_rco       = 1'b0;
        b4_ovf_clr   = 1'b0;
        ev_ready     = 1'b0;
        @(posedge clk);
        do_reset();

        // Reset state
        check("rst_valid", 32'(ev_valid), 32'd0);
        check("rst_data",  32'(ev_data),  32'd0);
        check("rst_count", 32'(ev_count), 32'd0);
        check("rst_ovf",   32'(ev_ovf),   32'd0);

        // Single rco edge at ts=5, consumer ready even while empty
        while (cyc < 5) step();
        b4_rco = 1'b1; b4_Q = 4'hF; ev_ready = 1'b1;
        step();
        check("t1_valid", 32'(ev_valid), 32'd1);
        check("t1_data",  32'(ev_data),  32'(ent(2'b01, 4'hF, 8'h05)));
        check("t1_count", 32'(ev_count), 32'd1);
        step();
        check("t1_popped_count", 32'(ev_count), 32'd0);
        check("t1_popped_valid", 32'(ev_valid), 32'd0);
        check("t1_popped_data",  32'(ev_data),  32'd0);
        b4_rco = 1'b0; ev_ready = 1'b0;

        // rco and load rise together at ts=0x20 -> one combined entry
        while (cyc < 32) step();
        b4_rco = 1'b1; b4_load = 1'b1; b4_Q = 4'h3;
        step();
        check("t2_data",  32'(ev_data),  32'(ent(2'b11, 4'h3, 8'h20)));
        check("t2_count", 32'(ev_count), 32'd1);
        step();
        check("t2_single_entry", 32'(ev_count), 32'd1);
        ev_ready = 1'b1;
        step();
        check("t2_drained", 32'(ev_count), 32'd0);
        ev_ready = 1'b0; b4_rco = 1'b0; b4_load = 1'b0;
        step();

        // Six edges with no consumer: four kept, overflow flagged
        for (int i = 0; i < 6; i++) begin
            b4_rco = 1'b1; b4_Q = 4'(i);
            exp_e[i] = ent(2'b01, 4'(i), cyc[7:0]);
            step();
            b4_rco = 1'b0;
            step();
        end
        check("t3_count", 32'(ev_count), 32'd4);
        check("t3_ovf",   32'(ev_ovf),   32'd1);
        check("t3_head",  32'(ev_data),  32'(exp_e[0]));
        // Clear coincident with another drop: set wins
        b4_rco = 1'b1; b4_ovf_clr = 1'b1;
        step();
        b4_rco = 1'b0; b4_ovf_clr = 1'b0;
        check("t3_set_wins_ovf", 32'(ev_ovf),   32'd1);
        check("t3_set_wins_cnt", 32'(ev_count), 32'd4);
        step();
        b4_ovf_clr = 1'b1;
        step();
        b4_ovf_clr = 1'b0;
        check("t3_clr_ovf",   32'(ev_ovf),   32'd0);
        check("t3_clr_count", 32'(ev_count), 32'd4);
        check("t3_clr_head",  32'(ev_data),  32'(exp_e[0]));
        ev_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check($sformatf("t3_order%0d", j), 32'(ev_data), 32'(exp_e[j]));
            step();
        end
        ev_ready = 1'b0;
        check("t3_empty_count", 32'(ev_count), 32'd0);
        check("t3_empty_data",  32'(ev_data),  32'd0);

        // Full FIFO, event and pop in the same cycle
        for (int i = 0; i < 4; i++) begin
            b4_rco = 1'b1; b4_Q = 4'(8 + i);
            exp_e[i] = ent(2'b01, 4'(8 + i), cyc[7:0]);
            step();
            b4_rco = 1'b0;
            step();
        end
        check("t4_full_count", 32'(ev_count), 32'd4);
        check("t4_full_ovf",   32'(ev_ovf),   32'd0);
        b4_rco = 1'b1; b4_Q = 4'hC; ev_ready = 1'b1;
        exp_new = ent(2'b01, 4'hC, cyc[7:0]);
        check("t4_head_before", 32'(ev_data), 32'(exp_e[0]));
        step();
        b4_rco = 1'b0; ev_ready = 1'b0;
        check("t4_count", 32'(ev_count), 32'd4);
        check("t4_ovf",   32'(ev_ovf),   32'd0);
        exp_e[4] = exp_new;
        ev_ready = 1'b1;
        for (int j = 1; j < 5; j++) begin
            check($sformatf("t4_order%0d", j), 32'(ev_data), 32'(exp_e[j]));
            step();
        end
        ev_ready = 1'b0;
        check("t4_drained", 32'(ev_count), 32'd0);

        // 300 cycles: rco held high from cycle 10, load pulses around the wrap
        do_reset();
        ev_ready = 1'b1;
        exp_e[0] = ent(2'b01, 4'hA, 8'h0A);
        exp_e[1] = ent(2'b10, 4'hE, 8'hFE);
        exp_e[2] = ent(2'b10, 4'h0, 8'h00);
        seen = 0;
        for (int c = 0; c < 300; c++) begin
            b4_rco  = (cyc >= 10);
            b4_load = (cyc == 254) || (cyc == 256);
            b4_Q    = cyc[3:0];
            step();
            if (ev_valid) begin
                if (seen < 3) begin
                    check($sformatf("t5_entry%0d", seen), 32'(ev_data), 32'(exp_e[seen]));
                end
                seen++;
            end
        end
        check("t5_event_total", 32'(seen), 32'd3);
        b4_rco = 1'b0; b4_load = 1'b0; ev_ready = 1'b0;
        step();

        // Reset mid-operation while rco rises
        for (int i = 0; i < 2; i++) begin
            b4_rco = 1'b1; b4_Q = 4'(i);
            step();
            b4_rco = 1'b0;
            step();
        end
        check("t6_queued", 32'(ev_count), 32'd2);
        b4_rco = 1'b1; ev_ready = 1'b1;
        do_reset();
        ev_ready = 1'b0;
        check("t6_valid", 32'(ev_valid), 32'd0);
        check("t6_count", 32'(ev_count), 32'd0);
        check("t6_ovf",   32'(ev_ovf),   32'd0);
        check("t6_data",  32'(ev_data),  32'd0);
        step(); step(); step();
        check("t6_held_no_event", 32'(ev_count), 32'd0);
        b4_rco = 1'b0;
        step();
        b4_rco = 1'b1; b4_Q = 4'h7;
        exp_new = ent(2'b01, 4'h7, cyc[7:0]);
        step();
        check("t6_new_edge_count", 32'(ev_count), 32'd1);
        check("t6_new_edge_data",  32'(ev_data),  32'(exp_new));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/counter_b4_event_log.md
COUNTER_B4_EVENT_LOG -- requirements
Module: counter_b4_event_log

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entries; only power-of-2 values 2..16 are legal.
REQ-002 SHALL have parameter TS_W, default 8, meaning timestamp width in bits.
REQ-003 SHALL have port b4_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port b4_reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port b4_Q  input  4  count value from the upstream 4-bit counter.
REQ-006 SHALL have port b4_load  input  1  load indication from the upstream counter.
REQ-007 SHALL have port b4_rco  input  1  ripple-carry-out from the upstream counter.
REQ-008 SHALL have port b4_ovf_clr  input  1  clears the sticky overflow flag.
REQ-009 SHALL have port ev_ready  input  1  consumer accepts the head entry.
REQ-010 SHALL have port ev_valid  output  1  head entry is valid.
REQ-011 SHALL have port ev_data  output  6+TS_W  head entry {type[1:0], q[3:0], ts[TS_W-1:0]}.
REQ-012 SHALL have port ev_count  output  log2(DEPTH)+1  current occupancy.
REQ-013 SHALL have port ev_ovf  output  1  sticky flag: an event was dropped.

Function
REQ-014 SHALL keep a free-running TS_W-bit timestamp: 0 after reset, +1 every cycle, wrapping from all-ones to 0.
REQ-015 SHALL register b4_rco and b4_load each cycle; a rising edge is input=1 while the registered value=0.
REQ-016 SHALL encode the event type as 2'b01 for an rco edge only, 2'b10 for a load edge only, and 2'b11 for both edges in the same cycle (one entry).
REQ-017 SHALL form each entry from the event type, b4_Q, and the timestamp, all sampled in the edge cycle.
REQ-018 SHALL write the entry at the end of the edge cycle; ev_valid is high from the next cycle (1-cycle latency).
REQ-019 SHALL pop the head when ev_valid && ev_ready at a clock edge; ev_data holds steady while ev_valid && !ev_ready.
REQ-020 SHALL present entries in arrival order (FIFO).
REQ-021 SHALL drive ev_data to 0 whenever ev_valid is 0.
REQ-022 Full (ev_count==DEPTH) with event and no pop: SHALL drop the event, keep contents, and set ev_ovf.
REQ-023 Full with event and a pop in the same cycle: SHALL accept both; ev_count stays DEPTH and ev_ovf is unchanged.
REQ-024 Empty with event: SHALL write the entry; ev_ready in that cycle has no effect.
REQ-025 SHALL ensure ev_ovf, once set, stays set until a cycle with b4_ovf_clr=1.
REQ-026 If b4_ovf_clr=1 and a drop occur in the same cycle, ev_ovf SHALL be 1 (set wins).
REQ-027 SHALL ensure a level held high generates exactly one event; the input must fall and rise again to generate another.

Reset
REQ-028 b4_reset=1 at a clock edge SHALL force: ev_valid=0, ev_data=0, ev_count=0, ev_ovf=0, timestamp=0, FIFO pointers=0.
REQ-029 SHALL set the registered rco and load values to 1 on reset, so inputs already high when reset releases generate no event.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries; events in a reset cycle are not logged and pops are ignored.
REQ-031 SHALL give reset priority over push, pop, and b4_ovf_clr.

Verification
REQ-032 Reset, then b4_rco 0->1 in cycle 5 (ts=5) with b4_Q=4'hF and ev_ready=1 -> ev_valid=1 in cycle 6 with ev_data={2'b01,4'hF,8'h05}; popped; ev_count returns to 0.
REQ-033 b4_load and b4_rco rise together with b4_Q=4'h3 at ts=8'h20 -> exactly one entry {2'b11,4'h3,8'h20}.
REQ-034 ev_ready=0, six rco edges -> ev_count=4, ev_ovf=1, first four events retained in order; b4_ovf_clr pulse -> ev_ovf=0, contents unchanged.
REQ-035 FIFO full, edge arrives in the same cycle as ev_ready=1 -> ev_count stays 4, ev_ovf stays 0, new entry at tail.
REQ-036 Run 300 cycles with b4_rco held high from cycle 10 -> exactly one event; timestamps observed across the 255->0 wrap are correct.
REQ-037 Two entries queued, b4_reset for one cycle while b4_rco rises -> ev_valid=0, ev_count=0, ev_ovf=0 next cycle; no entry is logged for that edge.
